// File: rtl/mux_n_pipe.sv
// ============================================================================
// Module      : mux_n_pipe
// Description : N-way lane select with registered output behind a 2-entry
//               skid buffer. Optional round-robin lane selection when
//               MUX_ROUND_ROBIN_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux_n_pipe #(
    parameter int WIDTH_DATA_LENGTH = 8,
    parameter int NUM_PORTS         = 4
) (
`ifdef MUX_ROUND_ROBIN_EN
    input  logic                                   rr_mode,
`endif
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [$clog2(NUM_PORTS)-1:0]           sel_port,
    input  logic [NUM_PORTS*WIDTH_DATA_LENGTH-1:0] port_in,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [WIDTH_DATA_LENGTH-1:0]           port_out,
    output logic                                   sel_err,
    output logic                                   out_valid,
    input  logic                                   out_ready
);

    localparam int SEL_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                         state_q;
    logic [WIDTH_DATA_LENGTH-1:0]   main_data_q;
    logic                           main_err_q;
    logic [WIDTH_DATA_LENGTH-1:0]   skid_data_q;
    logic                           skid_err_q;
    logic                           in_ready_q;
    logic                           out_valid_q;

    logic [SEL_W-1:0]               lane_sel;
    logic                           rr_active;
    logic [WIDTH_DATA_LENGTH-1:0]   acc_data_d;
    logic                           acc_err_d;
    logic                           w_accept;
    logic                           w_emit;

`ifdef MUX_ROUND_ROBIN_EN
    logic [SEL_W-1:0]               rr_sel_q;

    assign rr_active = rr_mode;
    assign lane_sel  = rr_mode ? rr_sel_q : sel_port;
`else
    assign rr_active = 1'b0;
    assign lane_sel  = sel_port;
`endif

    // Out-of-range selects (non-power-of-2 NUM_PORTS) fall through the loop
    // and leave data=0 with the error flag set.
    always_comb begin
        acc_data_d = '0;
        acc_err_d  = ~rr_active;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (lane_sel == k[SEL_W-1:0]) begin
                acc_data_d = port_in[k*WIDTH_DATA_LENGTH +: WIDTH_DATA_LENGTH];
                acc_err_d  = 1'b0;
            end
        end
    end

    assign w_accept = in_valid && in_ready_q;
    assign w_emit   = out_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef MUX_ROUND_ROBIN_EN
            rr_sel_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (w_accept) begin
                        main_data_q <= acc_data_d;
                        main_err_q  <= acc_err_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_emit) begin
                        skid_data_q <= acc_data_d;
                        skid_err_q  <= acc_err_d;
                        in_ready_q  <= 1'b0;
                        state_q     <= S_TWO;
                    end else if (w_accept && w_emit) begin
                        main_data_q <= acc_data_d;
                        main_err_q  <= acc_err_d;
                    end else if (w_emit) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only a drain can happen
                    if (w_emit) begin
                        main_data_q <= skid_data_q;
                        main_err_q  <= skid_err_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_ONE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= S_EMPTY;
                end
            endcase
`ifdef MUX_ROUND_ROBIN_EN
            if (w_accept && rr_mode) begin
                if (rr_sel_q == SEL_W'(NUM_PORTS - 1)) begin
                    rr_sel_q <= '0;
                end else begin
                    rr_sel_q <= rr_sel_q + 1'b1;
                end
            end
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign port_out  = main_data_q;
    assign sel_err   = main_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
// ============================================================================
// Module      : tb_mux_n_pipe
// Description : Bench for mux_n_pipe; drives a 4-lane and a 3-lane instance
//               against a queue-based reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mux_n_pipe;

    typedef struct {
        logic [7:0] d;
        logic       e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] lanes;
    logic        in_valid;
    logic        out_ready;
    logic        rr_mode;

    logic        rdy4, vld4, err4;
    logic [7:0]  out4;
    logic        rdy3, vld3, err3;
    logic [7:0]  out3;

    int          vec_cnt  = 0;
    int          fail_cnt = 0;

    beat_t       q4[$];
    beat_t       q3[$];
    int          rr4 = 0;
    int          rr3 = 0;

    always #5 clk = ~clk;

    mux_n_pipe #(.WIDTH_DATA_LENGTH(8), .NUM_PORTS(4)) u_dut4 (
`ifdef MUX_ROUND_ROBIN_EN
        .rr_mode   (rr_mode),
`endif
        .clk       (clk),
        .rst       (rst),
        .sel_port  (sel),
        .port_in   (lanes),
        .in_valid  (in_valid),
        .in_ready  (rdy4),
        .port_out  (out4),
        .sel_err   (err4),
        .out_valid (vld4),
        .out_ready (out_ready)
    );

    mux_n_pipe #(.WIDTH_DATA_LENGTH(8), .NUM_PORTS(3)) u_dut3 (
`ifdef MUX_ROUND_ROBIN_EN
        .rr_mode   (rr_mode),
`endif
        .clk       (clk),
        .rst       (rst),
        .sel_port  (sel),
        .port_in   (lanes[23:0]),
        .in_valid  (in_valid),
        .in_ready  (rdy3),
        .port_out  (out3),
        .sel_err   (err3),
        .out_valid (vld3),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected beat for an n-lane mux given the effective select
    function automatic beat_t mk(input int n, input int s, input logic [31:0] ln);
        beat_t b;
        if (s < n) begin
            b.d = ln[s*8 +: 8];
            b.e = 1'b0;
        end else begin
            b.d = 8'h00;
            b.e = 1'b1;
        end
        return b;
    endfunction

    task automatic cycle();
        bit    a4, e4, a3, e3, was_rst;
        beat_t b4, b3;
        a4 = in_valid && (q4.size() < 2);
        e4 = out_ready && (q4.size() > 0);
        a3 = in_valid && (q3.size() < 2);
        e3 = out_ready && (q3.size() > 0);
        b4 = mk(4, rr_mode ? rr4 : int'(sel), lanes);
        b3 = mk(3, rr_mode ? rr3 : int'(sel), lanes);
        was_rst = rst;
        @(posedge clk);
        if (was_rst) begin
            q4.delete();
            q3.delete();
            rr4 = 0;
            rr3 = 0;
        end else begin
            if (e4) void'(q4.pop_front());
            if (a4) begin
                q4.push_back(b4);
                if (rr_mode) rr4 = (rr4 + 1) % 4;
            end
            if (e3) void'(q3.pop_front());
            if (a3) begin
                q3.push_back(b3);
                if (rr_mode) rr3 = (rr3 + 1) % 3;
            end
        end
        #1;
        check("in_ready4",  {31'd0, rdy4}, {31'd0, q4.size() < 2});
        check("out_valid4", {31'd0, vld4}, {31'd0, q4.size() > 0});
        check("in_ready3",  {31'd0, rdy3}, {31'd0, q3.size() < 2});
        check("out_valid3", {31'd0, vld3}, {31'd0, q3.size() > 0});
        if (q4.size() > 0) begin
            check("data4", {24'd0, out4}, {24'd0, q4[0].d});
            check("err4",  {31'd0, err4}, {31'd0, q4[0].e});
        end else if (was_rst) begin
            check("rst_data4", {24'd0, out4}, 32'd0);
            check("rst_err4",  {31'd0, err4}, 32'd0);
        end
        if (q3.size() > 0) begin
            check("data3", {24'd0, out3}, {24'd0, q3[0].d});
            check("err3",  {31'd0, err3}, {31'd0, q3[0].e});
        end else if (was_rst) begin
            check("rst_data3", {24'd0, out3}, 32'd0);
            check("rst_err3",  {31'd0, err3}, 32'd0);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic r);
        in_valid  = v;
        sel       = s;
        out_ready = r;
        cycle();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sel       = 2'd0;
        rr_mode   = 1'b0;
        lanes     = 32'h44332211;

        // Reset held two cycles with a beat offered
        cycle();
        cycle();
        rst = 1'b0;

        // Back-to-back select sweep
        for (int s = 0; s < 4; s++) drive(1'b1, 2'(s), 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);

        // Backpressure: fill both entries, offer a third beat, then drain
        drive(1'b1, 2'd1, 1'b0);
        drive(1'b1, 2'd2, 1'b0);
        drive(1'b1, 2'd3, 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, 1'b1);

        // Out-of-range select on the 3-lane instance, then a legal one
        lanes = 32'hDDCCBBAA;
        drive(1'b1, 2'd3, 1'b1);
        drive(1'b1, 2'd2, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);

        // Reset while both entries are full
        drive(1'b1, 2'd0, 1'b0);
        drive(1'b1, 2'd1, 1'b0);
        rst = 1'b1;
        drive(1'b1, 2'd2, 1'b1);
        rst = 1'b0;
        drive(1'b0, 2'd0, 1'b1);

`ifdef MUX_ROUND_ROBIN_EN
        lanes   = 32'h44332211;
        rr_mode = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b1, 2'd0, 1'b1);
        rr_mode = 1'b0;
        drive(1'b0, 2'd0, 1'b1);
        rr_mode = 1'b1;
        drive(1'b1, 2'd0, 1'b1);
        drive(1'b0, 2'd0, 1'b1);
        rr_mode = 1'b0;
`endif

        // Randomised traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            lanes = $urandom;
            rst   = ($urandom_range(0, 63) == 0);
`ifdef MUX_ROUND_ROBIN_EN
            rr_mode = ($urandom_range(0, 3) == 0);
`endif
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;
        rr_mode = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule

`default_nettype wire
